// File: rtl/peripheral_uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small FIFO, exposed as
// RXDATA / STATUS / CTRL registers on the J1 I/O bus.
module peripheral_uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  input  logic        uart_rx,
  output logic        rx_led,
  output logic        rx_avail
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DCW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            sync_reg;
  logic                  prev_reg;
  logic [DCW-1:0]        div_reg;
  logic [3:0]            tick_cnt_reg;
  logic [2:0]            bit_cnt_reg;
  logic [7:0]            shift_reg;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_reg, rptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  ovf_reg, ferr_reg, rd_q_reg;

  logic line, fall, tick, busy;
  logic start_det, start_tick, sample_data, stop_tick;
  logic push, pop, flush, full, empty, rd_sel;
  logic [4:0] count5;
  logic unused_bits;

  assign unused_bits = ^d_in[15:3];
  assign line = sync_reg[1];
  assign fall = prev_reg & ~line;
  assign tick = (div_reg == DCW'(DIV - 1));

  // Metastability guard; reset to idle-high so reset release is not a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 2'b11;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], uart_rx};
      prev_reg <= line;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           div_reg <= '0;
    else if (start_det) div_reg <= '0;
    else if (tick)      div_reg <= '0;
    else                div_reg <= div_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (fall) state_next = START;
      START: if (tick && tick_cnt_reg == 4'd7) state_next = line ? IDLE : DATA;
      DATA:  if (tick && tick_cnt_reg == 4'd15 && bit_cnt_reg == 3'd7) state_next = STOP;
      STOP:  if (tick && tick_cnt_reg == 4'd15) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    start_det   = (state_reg == IDLE) && fall;
    start_tick  = (state_reg == START) && tick && (tick_cnt_reg == 4'd7);
    sample_data = (state_reg == DATA) && tick && (tick_cnt_reg == 4'd15);
    stop_tick   = (state_reg == STOP) && tick && (tick_cnt_reg == 4'd15);
  end

  // After the mid-start sample the tick count restarts so later samples land mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      if (start_det || start_tick) tick_cnt_reg <= '0;
      else if (tick && busy)       tick_cnt_reg <= tick_cnt_reg + 1'b1;
      if (start_det)        bit_cnt_reg <= '0;
      else if (sample_data) bit_cnt_reg <= bit_cnt_reg + 1'b1;
      if (sample_data) shift_reg <= {line, shift_reg[7:1]};
    end
  end

  assign full   = (count_reg == (DEPTH_LOG2+1)'(DEPTH));
  assign empty  = (count_reg == '0);
  assign rd_sel = cs && rd && (addr == 4'h0);
  assign flush  = cs && wr && (addr == 4'h4) && d_in[0];
  assign pop    = rd_sel && !rd_q_reg && !empty && !flush;
  assign push   = stop_tick && line && (!full || pop) && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      rd_q_reg  <= 1'b0;
    end else begin
      rd_q_reg <= rd_sel;
      if (flush) begin
        wptr_reg  <= '0;
        rptr_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) wptr_reg <= wptr_reg + 1'b1;
        if (pop)  rptr_reg <= rptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
    end
  end

  // A new error on the same cycle as its clear must survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg  <= 1'b0;
      ferr_reg <= 1'b0;
    end else begin
      if (stop_tick && line && full && !pop)        ovf_reg <= 1'b1;
      else if (cs && wr && addr == 4'h4 && d_in[1]) ovf_reg <= 1'b0;
      if (stop_tick && !line)                       ferr_reg <= 1'b1;
      else if (cs && wr && addr == 4'h4 && d_in[2]) ferr_reg <= 1'b0;
    end
  end

  assign count5   = 5'(count_reg);
  assign rx_led   = busy;
  assign rx_avail = !empty;

  always_comb begin
    d_out = 16'h0000;
    if (cs) begin
      case (addr)
        4'h0:    d_out = {8'h00, empty ? 8'h00 : mem[rptr_reg]};
        4'h2:    d_out = {3'b000, busy, ferr_reg, ovf_reg, full, empty, 3'b000, count5};
        default: d_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_uart_rx_fifo.sv
// Scoreboard bench for peripheral_uart_rx_fifo at DIV=4 (64 clocks per bit).
module tb_peripheral_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [15:0] d_in = 16'h0000;
  logic [15:0] d_out;
  logic        uart_rx = 1'b1;
  logic        rx_led, rx_avail;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q [$];

  peripheral_uart_rx_fifo #(
    .CLK_FREQ(6_400_000), .BAUD(100_000), .DEPTH_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .uart_rx(uart_rx),
    .rx_led(rx_led), .rx_avail(rx_avail)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    uart_rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (64) @(negedge clk);
    end
    uart_rx = stop_val;
    repeat (64) @(negedge clk);
    uart_rx = 1'b1;
    $display("frame sent %02h stop=%0d", b, stop_val);
  endtask

  task automatic read_reg(input logic [3:0] a, input int hold, output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    #2 v = d_out;
    repeat (hold) @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    $display("read addr %0h -> %04h", a, v);
  endtask

  task automatic write_ctrl(input logic [15:0] v);
    cs = 1'b1; wr = 1'b1; addr = 4'h4; d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
    @(negedge clk);
    $display("write ctrl %04h", v);
  endtask

  task automatic drain_check(input string name);
    logic [15:0] v;
    logic [7:0]  e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_reg(4'h0, 1, v);
      checks++;
      if (v !== {8'h00, e}) $display("FAIL %s rxdata got %04h want %04h", name, v, {8'h00, e});
      else passes++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (rx_led !== 1'b1) $display("FAIL reset_prebusy rx_led got %b want 1", rx_led); else passes++;
    rst = 1'b0;
    uart_rx = 1'b1;
    #1;
    checks++;
    if (rx_led !== 1'b0) $display("FAIL reset_async rx_led got %b want 0", rx_led); else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (rx_led !== 1'b0 || rx_avail !== 1'b0)
      $display("FAIL reset_outputs led/avail got %b%b want 00", rx_led, rx_avail); else passes++;
    checks++;
    if (d_out !== 16'h0000) $display("FAIL reset_dout_nocs got %04h want 0000", d_out); else passes++;
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0100) $display("FAIL reset_status got %04h want 0100", v); else passes++;
    read_reg(4'h0, 1, v);
    checks++;
    if (v !== 16'h0000) $display("FAIL reset_rxdata got %04h want 0000", v); else passes++;
  endtask

  task automatic test_single_byte();
    logic [15:0] v;
    logic [7:0]  e;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (300) @(negedge clk);
        checks++;
        if (rx_led !== 1'b1) $display("FAIL single_led got %b want 1", rx_led); else passes++;
      end
    join
    exp_q.push_back(8'h55);
    checks++;
    if (rx_avail !== 1'b1) $display("FAIL single_avail got %b want 1", rx_avail); else passes++;
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0001) $display("FAIL single_status got %04h want 0001", v); else passes++;
    send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hC3);
    e = exp_q.pop_front();
    read_reg(4'h0, 3, v);
    checks++;
    if (v !== {8'h00, e}) $display("FAIL single_hold_rd got %04h want %04h", v, {8'h00, e}); else passes++;
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0001) $display("FAIL single_one_pop status got %04h want 0001", v); else passes++;
    drain_check("single");
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0100) $display("FAIL single_empty status got %04h want 0100", v); else passes++;
  endtask

  task automatic test_fill_overflow();
    logic [15:0] v;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      if (i < 16) exp_q.push_back(8'(i));
    end
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0610) $display("FAIL fill_status got %04h want 0610", v); else passes++;
    drain_check("fill");
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0500) $display("FAIL fill_drained status got %04h want 0500", v); else passes++;
    write_ctrl(16'h0002);
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0100) $display("FAIL ovf_clear status got %04h want 0100", v); else passes++;
  endtask

  task automatic test_frame_err_glitch();
    logic [15:0] v;
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h11);
    send_frame(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0801) $display("FAIL ferr_status got %04h want 0801", v); else passes++;
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (rx_led !== 1'b1) $display("FAIL glitch_led got %b want 1", rx_led); else passes++;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (rx_led !== 1'b0) $display("FAIL glitch_idle rx_led got %b want 0", rx_led); else passes++;
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0801) $display("FAIL glitch_status got %04h want 0801", v); else passes++;
    write_ctrl(16'h0004);
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0001) $display("FAIL ferr_clear status got %04h want 0001", v); else passes++;
    drain_check("ferr");
  endtask

  // Start edge sampled at the 1st posedge after the frame begins; push lands in
  // the cycle ending at the 611th posedge.
  task automatic test_simultaneous();
    logic [15:0] v;
    logic [7:0]  e;
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1);
      exp_q.push_back(8'h20 + 8'(i));
    end
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (610) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        read_reg(4'h0, 1, v);
        exp_q.push_back(8'h77);
        checks++;
        if (v !== {8'h00, e}) $display("FAIL simul_rd got %04h want %04h", v, {8'h00, e}); else passes++;
      end
    join
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0210) $display("FAIL simul_status got %04h want 0210", v); else passes++;
    drain_check("simul");
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0100) $display("FAIL simul_empty status got %04h want 0100", v); else passes++;
  endtask

  task automatic test_flush_collision();
    logic [15:0] v;
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (610) @(posedge clk);
        @(negedge clk);
        write_ctrl(16'h0001);
      end
    join
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0100) $display("FAIL flush_status got %04h want 0100", v); else passes++;
    checks++;
    if (rx_avail !== 1'b0) $display("FAIL flush_avail got %b want 0", rx_avail); else passes++;
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    drain_check("flush");
    read_reg(4'h2, 1, v);
    checks++;
    if (v !== 16'h0100) $display("FAIL flush_after status got %04h want 0100", v); else passes++;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_frame_err_glitch();
    test_simultaneous();
    test_flush_collision();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/peripheral_uart_rx_fifo.md
# peripheral_uart_rx_fifo

Buffered UART receive peripheral for the J1 I/O bus. It deserialises 8N1 frames from the ESP module's TX line, queues the received bytes in a 16-entry FIFO, and exposes data, status and control registers through the same chip-select/rd/wr/addr[3:0] interface as the other J1 peripherals. It sits upstream of the J1 firmware. It lets AT-command responses from the ESP arrive in bursts without byte loss while the CPU is busy.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency, in Hz.
- BAUD, 115200: line rate. The 16x oversample divider is DIV = CLK_FREQ/(BAUD*16), truncated, and DIV must be ≥ 2.
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default).

Ports (clock and reset first):
- clk, input, 1: system clock. It is the only clock.
- rst, input, 1: asynchronous, active-low reset.
- cs, input, 1: chip select from the SoC address decoder.
- rd, input, 1: J1 read strobe.
- wr, input, 1: J1 write strobe.
- addr, input, 4: register select, j1_io_addr[3:0].
- d_in, input, 16: write data from J1.
- d_out, output, 16: read data to the J1 mux.
- uart_rx, input, 1: asynchronous serial input, idle high.
- rx_led, output, 1: high while a frame is being received.
- rx_avail, output, 1: high whenever the FIFO is not empty.

## Operation
Register map:
- addr 4'h0, read: RXDATA = {8'h00, head byte}.
  - The first cycle of cs&rd&(addr==0) pops one entry. This is rising-edge detected, so holding rd high pops only once.
  - A pop while empty has no effect and returns 16'h0000.
- addr 4'h2, read: STATUS = {3'b0, busy, frame_err, overflow, full, empty, 3'b0, count[4:0]}.
  - busy = bit 12, frame_err = bit 11, overflow = bit 10, full = bit 9, empty = bit 8.
  - count ranges from 0 to 16.
- addr 4'h4, write: CTRL. On any cycle with cs&wr:
  - d_in[0] flushes the FIFO (count goes to 0).
  - d_in[1] clears overflow.
  - d_in[2] clears frame_err.
- d_out = 16'h0000 when cs=0 or addr is not mapped. d_out is combinational from the current head and flags.

Receiver:
- uart_rx passes through a 2-flop synchronizer before use.
- The 16x tick counter is free-running and is reloaded when a start edge is detected.

Receiver state machine:
- IDLE: wait for a falling edge (previous sample high, current sample low). A line held low does not retrigger.
- START: after 8 ticks, sample the line. If low, go to DATA. If high, treat it as a glitch and return to IDLE; nothing is pushed and no flag is set.
- DATA: sample every 16 ticks, 8 bits, LSB first.
- STOP: sample after 16 ticks.
  - If high and the FIFO is not full: push the byte.
  - If high and the FIFO is full: drop the byte and set overflow.
  - If low: drop the byte and set frame_err.
  - In all three cases, go to IDLE.

FIFO and flag rules:
- Pointers wrap modulo 2^DEPTH_LOG2. count is kept separately so that full and empty are unambiguous.
- Push and pop on the same cycle are both performed and count is unchanged. This includes full+pop (the push is accepted) and empty+push (the pop is ignored and count becomes 1).
- Flush on the same cycle as a push: flush wins, the byte is discarded, and count = 0.
- A clear on the same cycle as a new set of the same flag: set wins.
- rx_led = busy = (state != IDLE). rx_avail = ~empty.

## Timing
Reset (rst=0, asynchronous):
- State goes to IDLE.
- Pointers and count go to 0.
- overflow and frame_err go to 0.
- rx_led=0, rx_avail=0, d_out=0. STATUS reads 16'h0100 once cs is applied.
- Synchronizer flops are reset to 1, so reset release with the line idle produces no false start.
- A reset mid-frame aborts the frame, and the partial byte is lost.

Latency:
- The push happens on the STOP sampling tick. count, empty and rx_avail update on the next clk edge.
- From the uart_rx falling edge to rx_avail high: 2 sync cycles plus (8+128+16) ticks plus 1 cycle, i.e. about 152·16·DIV/16 clocks (one baud period = 16·DIV clocks).
- Pop: the head is valid in the same cycle as the rd strobe. The pointer and count advance at the end of that cycle, and the next entry is visible from the following cycle.
- Flag clears and flush take effect at the clk edge that ends the write cycle.
- Maximum sustained input rate is back-to-back frames (stop bit immediately followed by a start bit). START detection restarts in IDLE the cycle after STOP.

## Test plan
Bench setup: CLK_FREQ=6_400_000, BAUD=100_000, so DIV=4 and a bit lasts 64 clocks.
- **Reset:** assert rst=0 mid-sim, then release. STATUS reads 16'h0100, rx_led=0, rx_avail=0, and RXDATA reads 16'h0000.
- **Single byte:** send frame 0x55. rx_led is high during the frame, then rx_avail=1 and STATUS count=1. Read RXDATA → 16'h0055, after which STATUS → 16'h0100. Holding rd for 3 cycles pops only once.
- **Fill and overflow:** send bytes 0x00..0x10 (17 frames) without reading.
  - STATUS → full=1, count=16, overflow=1.
  - 16 reads return 0x00..0x0F in order; 0x10 is lost.
  - Write CTRL 16'h0002 → overflow=0.
- **Frame error and glitch:**
  - Send 0xA5 with the stop bit forced low → frame_err=1 and count unchanged.
  - Drive a 20-clock low pulse → no push, no flag, and the FSM returns to IDLE.
  - Write CTRL 16'h0004 → frame_err=0.
- **Simultaneous push/pop:** with count=16, time an RXDATA read on the STOP tick of a new frame. count stays 16, no overflow is set, and the new byte is read last.
- **Flush collision:** write CTRL 16'h0001 on the push cycle of a frame. count=0, empty=1, and that byte never appears.
